// File: rtl/aes_top.sv
// Iterative AES-128 encrypt/decrypt engine: key expansion into 11 round-key
// registers, then one cipher round per clock; result held on data_out.
module aes_top (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic [127:0] data_in,
  input  logic         enable,
  input  logic         ED,
  output logic         completedFlag,
  output logic [127:0] data_out
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic         ed_q;
  logic         flag_q;
  logic [127:0] data_q;
  logic [127:0] st_q;
  logic [127:0] data_out_q;
  logic [127:0] rk_q [0:10];
  logic [127:0] round_d;
  logic [127:0] rk_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 as AES requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = 128'h0;
    for (int k = 0; k < 16; k++) begin
      if (inv) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
      else     o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    end
    return o;
  endfunction

  // Byte index is row + 4*column; row r rotates left by r (right when inv)
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
        else     o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      if (inv) begin
        o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end else begin
        o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {rk[23:0], rk[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h000000};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Next round key from the previous one
  always_comb begin
    rk_d = key_step(rk_q[cnt_q - 4'd1], rcon(cnt_q));
  end

  // One cipher or inverse-cipher round selected by the latched direction
  always_comb begin
    logic [127:0] t;
    t       = 128'h0;
    round_d = 128'h0;
    if (cnt_q == 4'd0) begin
      if (ed_q) round_d = data_q ^ rk_q[0];
      else      round_d = data_q ^ rk_q[10];
    end else if (ed_q) begin
      t = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
      if (cnt_q != 4'd10) t = mix_columns(t, 1'b0);
      else                t = t;
      round_d = t ^ rk_q[cnt_q];
    end else begin
      t = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk_q[4'd10 - cnt_q];
      if (cnt_q != 4'd10) round_d = mix_columns(t, 1'b1);
      else                round_d = t;
    end
  end

  // Control FSM, round-key storage and result register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ed_q       <= 1'b0;
      flag_q     <= 1'b0;
      data_q     <= 128'h0;
      st_q       <= 128'h0;
      data_out_q <= 128'h0;
      for (int i = 0; i < 11; i++) rk_q[i] <= 128'h0;
    end else begin
      case (state_q)
        IDLE: begin
          flag_q <= 1'b0;
          if (enable) begin
            data_q   <= data_in;
            ed_q     <= ED;
            rk_q[0]  <= key;
            cnt_q    <= 4'd1;
            state_q  <= KEYEXP;
          end else begin
            state_q  <= IDLE;
          end
        end
        KEYEXP: begin
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            rk_q[cnt_q] <= rk_d;
            if (cnt_q == 4'd10) begin
              cnt_q   <= 4'd0;
              state_q <= ROUND;
            end else begin
              cnt_q   <= cnt_q + 4'd1;
            end
          end
        end
        ROUND: begin
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            st_q <= round_d;
            if (cnt_q == 4'd10) begin
              data_out_q <= round_d;
              flag_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              cnt_q      <= cnt_q + 4'd1;
            end
          end
        end
        DONE: begin
          flag_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign completedFlag = flag_q;
  assign data_out      = data_out_q;

endmodule

// File: tb/tb_aes_top.sv
// Directed bench for aes_top using FIPS-197 known-answer vectors.
module tb_aes_top;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] key;
  logic [127:0] data_in;
  logic         enable;
  logic         ED;
  logic         completedFlag;
  logic [127:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_top dut (
    .clock        (clock),
    .reset        (reset),
    .key          (key),
    .data_in      (data_in),
    .enable       (enable),
    .ED           (ED),
    .completedFlag(completedFlag),
    .data_out     (data_out)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks until the next completedFlag sample (at least one edge), bounded
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (completedFlag !== 1'b1 && n < 40);
  endtask

  // Starts a run one edge ahead of sampling; optionally scrambles inputs at edge pert
  task automatic run_vec(input string tag, input logic [127:0] k, input logic [127:0] d,
                         input logic e, input logic [127:0] exp, input int pert);
    int n;
    n       = 0;
    key     = k;
    data_in = d;
    ED      = e;
    enable  = 1'b1;
    while (completedFlag !== 1'b1 && n < 30) begin
      tick();
      n++;
      if (pert != 0 && n == pert) begin
        key     = ~k;
        data_in = ~d;
        ED      = ~e;
      end
    end
    check_eq({tag, " latency"}, 128'(n), 128'd22);
    check_eq({tag, " data"}, data_out, exp);
    enable = 1'b0;
    tick();
    check_eq({tag, " pulse width"}, 128'(completedFlag), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    reset   = 1'b1;
    enable  = 1'b0;
    ED      = 1'b1;
    key     = 128'h0;
    data_in = 128'h0;
    repeat (3) tick();
    check_eq("reset data_out", data_out, 128'h0);
    check_eq("reset flag", 128'(completedFlag), 128'd0);

    // Reset wins over enable on the same edge
    key     = C1_KEY;
    data_in = C1_PT;
    enable  = 1'b1;
    tick();
    check_eq("reset+enable flag", 128'(completedFlag), 128'd0);
    reset = 1'b0;
    run_vec("c1 enc", C1_KEY, C1_PT, 1'b1, C1_CT, 0);
    run_vec("c1 dec", C1_KEY, C1_CT, 1'b0, C1_PT, 0);
    run_vec("b enc", B_KEY, B_PT, 1'b1, B_CT, 0);
    run_vec("b dec", B_KEY, B_CT, 1'b0, B_PT, 0);

    // Inputs changed during ROUND are ignored
    run_vec("midrun dec", C1_KEY, C1_CT, 1'b0, C1_PT, 15);
    run_vec("midrun enc", B_KEY, B_PT, 1'b1, B_CT, 16);

    // Reset during ROUND
    key     = C1_KEY;
    data_in = C1_PT;
    ED      = 1'b1;
    enable  = 1'b1;
    repeat (15) tick();
    reset = 1'b1;
    tick();
    check_eq("midrun reset data_out", data_out, 128'h0);
    check_eq("midrun reset flag", 128'(completedFlag), 128'd0);
    reset  = 1'b0;
    enable = 1'b0;
    tick();

    // Abort during KEYEXP keeps the prior result and gives no pulse
    run_vec("pre-abort", C1_KEY, C1_PT, 1'b1, C1_CT, 0);
    key     = B_KEY;
    data_in = B_PT;
    ED      = 1'b1;
    enable  = 1'b1;
    repeat (5) tick();
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (completedFlag === 1'b1) pulses++;
    end
    check_eq("abort pulses", 128'(pulses), 128'd0);
    check_eq("abort data_out", data_out, C1_CT);

    // Free-running with an unknown direction, then a known vector
    key     = B_KEY;
    data_in = B_PT;
    ED      = 1'bx;
    enable  = 1'b1;
    repeat (500) tick();
    key     = C1_KEY;
    data_in = C1_PT;
    ED      = 1'b1;
    n = 0;
    while (data_out !== C1_CT && n < 46) begin
      tick();
      n++;
    end
    check_eq("free converge", data_out, C1_CT);
    wait_pulse(n);
    for (int j = 0; j < 3; j++) begin
      wait_pulse(n);
      check_eq("free period", 128'(n), 128'd23);
      check_eq("free data", data_out, C1_CT);
    end
    enable = 1'b0;
    repeat (30) tick();
    check_eq("final flag", 128'(completedFlag), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
